// File: rtl/flags_unit.sv
// Banked NZCV condition-flag store with compare, direct-write and condition-evaluate ports.
// Latency: cmp/wr update the banks at the next edge; eval result is registered (1 cycle).
// Backpressure: eval uses valid/ready with a single output register; cmp/wr are always accepted.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   cmp_valid_i/bank_i/a_i/b_i      compare request: flags from a - b written to one bank
//   wr_valid_i/bank_i/mask_i/flags_i direct masked flag write {N,Z,C,V}
//   ev_valid_i/ready_o/bank_i/cond_i evaluate request (accepted on valid && ready)
//   ev_valid_o/ready_i/true_o/flags_o evaluate result and the {N,Z,C,V} it was computed from

module flags_unit #(
  parameter int WIDTH = 8,
  parameter int NBANK = 4,
  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic             clk,
  input  logic             reset,
  // compare port
  input  logic             cmp_valid_i,
  input  logic [BW-1:0]    cmp_bank_i,
  input  logic [WIDTH-1:0] cmp_a_i,
  input  logic [WIDTH-1:0] cmp_b_i,
  // direct write port
  input  logic             wr_valid_i,
  input  logic [BW-1:0]    wr_bank_i,
  input  logic [3:0]       wr_mask_i,
  input  logic [3:0]       wr_flags_i,
  // evaluate request
  input  logic             ev_valid_i,
  output logic             ev_ready_o,
  input  logic [BW-1:0]    ev_bank_i,
  input  logic [3:0]       ev_cond_i,
  // evaluate result
  output logic             ev_valid_o,
  input  logic             ev_ready_i,
  output logic             ev_true_o,
  output logic [3:0]       ev_flags_o
);

  // Condition codes, flag vector ordering is {N,Z,C,V}
  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, r;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    r = 1'b0;
    case (cond_e'(cc))
      COND_EQ: r = z;
      COND_NE: r = !z;
      COND_CS: r = c;
      COND_CC: r = !c;
      COND_MI: r = n;
      COND_PL: r = !n;
      COND_VS: r = v;
      COND_VC: r = !v;
      COND_HI: r = c && !z;
      COND_LS: r = !c || z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = !z && (n == v);
      COND_LE: r = z || (n != v);
      COND_AL: r = 1'b1;
      COND_NV: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Compare flag generation: a + ~b + 1, carry out is "no borrow"
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   cmp_sum;
  logic [WIDTH-1:0] cmp_diff;
  logic [3:0]       cmp_flags;

  always_comb begin
    cmp_sum  = {1'b0, cmp_a_i} + {1'b0, ~cmp_b_i} + (WIDTH+1)'(1);
    cmp_diff = cmp_sum[WIDTH-1:0];
    cmp_flags[3] = cmp_diff[WIDTH-1];
    cmp_flags[2] = (cmp_diff == '0);
    cmp_flags[1] = cmp_sum[WIDTH];
    // Overflow: operand signs differ and the result sign differs from a
    cmp_flags[0] = (cmp_a_i[WIDTH-1] != cmp_b_i[WIDTH-1]) &&
                   (cmp_diff[WIDTH-1] != cmp_a_i[WIDTH-1]);
  end

  // ---------------------------------------------------------------------------
  // Bank state: compare writes all four bits, the direct write then overrides
  // its masked bits. Indices >= NBANK match no bank, so they are dropped.
  // ---------------------------------------------------------------------------
  logic [3:0] bank_q [NBANK];
  logic [3:0] bank_d [NBANK];

  always_comb begin
    for (int i = 0; i < NBANK; i++) begin
      bank_d[i] = bank_q[i];
      if (cmp_valid_i && (cmp_bank_i == BW'(i))) begin
        bank_d[i] = cmp_flags;
      end
      if (wr_valid_i && (wr_bank_i == BW'(i))) begin
        bank_d[i] = (bank_d[i] & ~wr_mask_i) | (wr_flags_i & wr_mask_i);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NBANK; i++) begin
      if (reset) begin
        bank_q[i] <= 4'b0000;
      end else begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Evaluation reads the bank's next value so a same-cycle cmp/wr is forwarded.
  // An out-of-range bank index evaluates against all-zero flags.
  // ---------------------------------------------------------------------------
  logic [3:0] ev_sel_flags;
  logic       ev_sel_true;

  always_comb begin
    ev_sel_flags = 4'b0000;
    for (int i = 0; i < NBANK; i++) begin
      if (ev_bank_i == BW'(i)) begin
        ev_sel_flags = bank_d[i];
      end
    end
    ev_sel_true = cond_eval(ev_cond_i, ev_sel_flags);
  end

  // ---------------------------------------------------------------------------
  // Single-entry output register. A held result is frozen until consumed;
  // the banks keep updating underneath it without re-evaluation.
  // ---------------------------------------------------------------------------
  logic       ev_valid_q, ev_valid_d;
  logic       ev_true_q,  ev_true_d;
  logic [3:0] ev_flags_q, ev_flags_d;
  logic       ev_accept;

  assign ev_ready_o = !ev_valid_q || ev_ready_i;
  assign ev_accept  = ev_valid_i && ev_ready_o;

  always_comb begin
    ev_valid_d = ev_valid_q && !ev_ready_i;
    ev_true_d  = ev_true_q;
    ev_flags_d = ev_flags_q;
    if (ev_accept) begin
      ev_valid_d = 1'b1;
      ev_true_d  = ev_sel_true;
      ev_flags_d = ev_sel_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ev_valid_q <= 1'b0;
      ev_true_q  <= 1'b0;
      ev_flags_q <= 4'b0000;
    end else begin
      ev_valid_q <= ev_valid_d;
      ev_true_q  <= ev_true_d;
      ev_flags_q <= ev_flags_d;
    end
  end

  assign ev_valid_o = ev_valid_q;
  assign ev_true_o  = ev_true_q;
  assign ev_flags_o = ev_flags_q;

endmodule

// File: tb/tb_flags_unit.sv
// Directed self-checking bench for flags_unit (WIDTH=8, NBANK=4).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// Expected values below are hand-derived from the subtract/condition rules.

module tb_flags_unit;

  logic       clk;
  logic       reset;
  logic       cmp_valid_i;
  logic [1:0] cmp_bank_i;
  logic [7:0] cmp_a_i;
  logic [7:0] cmp_b_i;
  logic       wr_valid_i;
  logic [1:0] wr_bank_i;
  logic [3:0] wr_mask_i;
  logic [3:0] wr_flags_i;
  logic       ev_valid_i;
  logic       ev_ready_o;
  logic [1:0] ev_bank_i;
  logic [3:0] ev_cond_i;
  logic       ev_valid_o;
  logic       ev_ready_i;
  logic       ev_true_o;
  logic [3:0] ev_flags_o;

  int checks   = 0;
  int failures = 0;

  flags_unit #(.WIDTH(8), .NBANK(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmp_valid_i(cmp_valid_i),
    .cmp_bank_i (cmp_bank_i),
    .cmp_a_i    (cmp_a_i),
    .cmp_b_i    (cmp_b_i),
    .wr_valid_i (wr_valid_i),
    .wr_bank_i  (wr_bank_i),
    .wr_mask_i  (wr_mask_i),
    .wr_flags_i (wr_flags_i),
    .ev_valid_i (ev_valid_i),
    .ev_ready_o (ev_ready_o),
    .ev_bank_i  (ev_bank_i),
    .ev_cond_i  (ev_cond_i),
    .ev_valid_o (ev_valid_o),
    .ev_ready_i (ev_ready_i),
    .ev_true_o  (ev_true_o),
    .ev_flags_o (ev_flags_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Check the full output register: valid, true, flags
  task automatic chk_out(input string tag, input logic v, input logic t, input logic [3:0] f);
    chk({tag, ".valid"}, {7'b0, ev_valid_o}, {7'b0, v});
    chk({tag, ".true"},  {7'b0, ev_true_o},  {7'b0, t});
    chk({tag, ".flags"}, {4'b0, ev_flags_o}, {4'b0, f});
  endtask

  // One-cycle eval request, ready held high
  task automatic eval1(input logic [1:0] bank, input logic [3:0] cond);
    ev_valid_i = 1'b1;
    ev_bank_i  = bank;
    ev_cond_i  = cond;
    tick();
    ev_valid_i = 1'b0;
    cmp_valid_i = 1'b0;
    wr_valid_i  = 1'b0;
  endtask

  task automatic set_cmp(input logic [1:0] bank, input logic [7:0] a, input logic [7:0] b);
    cmp_valid_i = 1'b1;
    cmp_bank_i  = bank;
    cmp_a_i     = a;
    cmp_b_i     = b;
  endtask

  initial begin
    reset = 1'b1;
    cmp_valid_i = 1'b0; cmp_bank_i = '0; cmp_a_i = '0; cmp_b_i = '0;
    wr_valid_i = 1'b0; wr_bank_i = '0; wr_mask_i = '0; wr_flags_i = '0;
    ev_valid_i = 1'b0; ev_bank_i = '0; ev_cond_i = '0; ev_ready_i = 1'b1;
    tick();
    tick();
    chk_out("reset", 1'b0, 1'b0, 4'b0000);
    chk("reset.ready", {7'b0, ev_ready_o}, 8'd1);
    reset = 1'b0;

    // 1. Fresh banks are all zero
    eval1(2'd2, 4'h0); chk_out("t1.eq", 1'b1, 1'b0, 4'b0000);
    eval1(2'd2, 4'hE); chk_out("t1.al", 1'b1, 1'b1, 4'b0000);
    eval1(2'd2, 4'hF); chk_out("t1.nv", 1'b1, 1'b0, 4'b0000);

    // 2. 05-05: Z=1 C=1, forwarded into the same-cycle eval
    set_cmp(2'd1, 8'h05, 8'h05);
    eval1(2'd1, 4'h0); chk_out("t2.eq", 1'b1, 1'b1, 4'b0110);
    eval1(2'd1, 4'h8); chk_out("t2.hi", 1'b1, 1'b0, 4'b0110);
    eval1(2'd1, 4'h9); chk_out("t2.ls", 1'b1, 1'b1, 4'b0110);

    // 3. 80-01 = 7F: C=1, signed overflow V=1
    set_cmp(2'd0, 8'h80, 8'h01);
    eval1(2'd0, 4'h6); chk_out("t3.vs", 1'b1, 1'b1, 4'b0011);
    eval1(2'd0, 4'hB); chk_out("t3.lt", 1'b1, 1'b1, 4'b0011);
    eval1(2'd0, 4'hA); chk_out("t3.ge", 1'b1, 1'b0, 4'b0011);
    eval1(2'd0, 4'h1); chk_out("t3.ne", 1'b1, 1'b1, 4'b0011);
    eval1(2'd3, 4'h0); chk_out("t3.bank3", 1'b1, 1'b0, 4'b0000);

    // 4. 03-05 = FE with borrow: N=1 C=0
    set_cmp(2'd2, 8'h03, 8'h05);
    eval1(2'd2, 4'h3); chk_out("t4.cc", 1'b1, 1'b1, 4'b1000);
    eval1(2'd2, 4'h4); chk_out("t4.mi", 1'b1, 1'b1, 4'b1000);
    eval1(2'd2, 4'hB); chk_out("t4.lt", 1'b1, 1'b1, 4'b1000);
    eval1(2'd2, 4'hC); chk_out("t4.gt", 1'b1, 1'b0, 4'b1000);
    // 00-FF = 01 with borrow: all flags clear
    set_cmp(2'd2, 8'h00, 8'hFF);
    eval1(2'd2, 4'h3); chk_out("t4.cc2", 1'b1, 1'b1, 4'b0000);

    // 5. Masked write overrides Z from the same-cycle compare
    set_cmp(2'd1, 8'h05, 8'h05);
    wr_valid_i = 1'b1; wr_bank_i = 2'd1; wr_mask_i = 4'b0100; wr_flags_i = 4'b0000;
    eval1(2'd1, 4'h0); chk_out("t5.eq", 1'b1, 1'b0, 4'b0010);
    eval1(2'd1, 4'h2); chk_out("t5.stored", 1'b1, 1'b1, 4'b0010);
    // Different banks in one cycle: both update (bank3 cmp, bank0 write)
    set_cmp(2'd3, 8'h05, 8'h05);
    wr_valid_i = 1'b1; wr_bank_i = 2'd0; wr_mask_i = 4'b1111; wr_flags_i = 4'b1001;
    tick();
    cmp_valid_i = 1'b0; wr_valid_i = 1'b0;
    eval1(2'd3, 4'h0); chk_out("t5.b3", 1'b1, 1'b1, 4'b0110);
    eval1(2'd0, 4'hA); chk_out("t5.b0", 1'b1, 1'b1, 4'b1001);

    // 6. Backpressure: load a result, then stall with a new request pending
    eval1(2'd0, 4'h6); chk_out("t6.load", 1'b1, 1'b1, 4'b1001);
    ev_ready_i = 1'b0;
    ev_valid_i = 1'b1; ev_bank_i = 2'd1; ev_cond_i = 4'h0;
    set_cmp(2'd0, 8'h05, 8'h05);     // bank0 -> 0110 under the held result
    #1;
    chk("t6.rdy_lo", {7'b0, ev_ready_o}, 8'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      cmp_valid_i = 1'b0;
      chk_out("t6.hold", 1'b1, 1'b1, 4'b1001);
      chk("t6.hold.rdy", {7'b0, ev_ready_o}, 8'd0);
    end
    ev_ready_i = 1'b1;
    #1;
    chk("t6.rdy_hi", {7'b0, ev_ready_o}, 8'd1);
    tick();                            // pending bank1 eq request taken
    chk_out("t6.pend", 1'b1, 1'b0, 4'b0010);
    ev_bank_i = 2'd0; ev_cond_i = 4'h0;
    tick();                            // back-to-back: bank0 now 0110
    chk_out("t6.b2b", 1'b1, 1'b1, 4'b0110);
    ev_valid_i = 1'b0;
    tick();
    chk_out("t6.drain", 1'b0, 1'b1, 4'b0110);

    // Reset during a held result drops it and clears the banks
    eval1(2'd0, 4'hE); chk_out("t6.pre", 1'b1, 1'b1, 4'b0110);
    ev_ready_i = 1'b0;
    tick();
    chk_out("t6.held", 1'b1, 1'b1, 4'b0110);
    reset = 1'b1;
    tick();
    chk_out("t6.rst", 1'b0, 1'b0, 4'b0000);
    reset = 1'b0;
    ev_ready_i = 1'b1;
    eval1(2'd0, 4'h0); chk_out("t6.bank_rst", 1'b1, 1'b0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
